// File: rtl/exit_ctrl.sv
// Simulation exit controller: OBI register slave that drains, then requests harness exit.
// Optional watchdog enabled by defining EXIT_CTRL_WDOG_EN.
module exit_ctrl #(
   parameter int unsigned DRAIN_CYCLES   = 16,
   parameter logic [31:0] WDOG_EXIT_CODE = 32'hDEAD_0001
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        exit_valid_o,
   output logic [31:0] exit_value_o
);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] exit_value_q;
   logic [31:0] cycle_cnt_q;
   logic [7:0]  drain_cnt_q;
   logic [31:0] wdog_rdata;
   logic [31:0] read_mux;
   logic [1:0]  word;
   logic        wr, rd, cfg_open, sw_exit, wdog_expire;
   logic        unused_bits;

   assign gnt_o    = req_i;
   assign word     = addr_i[3:2];
   assign wr       = req_i & we_i;
   assign rd       = req_i & ~we_i;
   assign cfg_open = (state_q == RUN);
   assign sw_exit  = cfg_open & wr & (word == 2'd1) & wdata_i[0];

`ifdef EXIT_CTRL_WDOG_EN
   logic [31:0] wdog_limit_q;
   logic [31:0] wdog_cnt_q;

   // Expiry is taken on the edge where the counter would reach the limit
   assign wdog_expire = cfg_open & (wdog_limit_q != 32'd0) & ((wdog_cnt_q + 32'd1) == wdog_limit_q);
   assign wdog_rdata  = wdog_limit_q;
   assign unused_bits = ^addr_i[1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wdog_limit_q <= 32'd0;
         wdog_cnt_q   <= 32'd0;
      end else if (cfg_open && wr && word == 2'd2) begin
         wdog_limit_q <= wdata_i;
         wdog_cnt_q   <= 32'd0;
      end else if (cfg_open && wdog_limit_q != 32'd0) begin
         wdog_cnt_q   <= wdog_cnt_q + 32'd1;
      end
   end
`else
   assign wdog_expire = 1'b0;
   assign wdog_rdata  = 32'd0;
   assign unused_bits = ^{addr_i[1:0], WDOG_EXIT_CODE};
`endif

   always_comb begin
      read_mux = 32'd0;
      case (word)
         2'd0:    read_mux = exit_value_q;
         2'd2:    read_mux = wdog_rdata;
         2'd3:    read_mux = cycle_cnt_q;
         default: read_mux = 32'd0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      exit_valid_o = 1'b0;
      case (state_q)
         RUN:     if (sw_exit || wdog_expire) state_d = DRAIN;
         DRAIN:   if (drain_cnt_q == 8'd1) state_d = DONE;
         DONE:    exit_valid_o = 1'b1;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         exit_value_q <= 32'd0;
         exit_value_o <= 32'd0;
         cycle_cnt_q  <= 32'd0;
         drain_cnt_q  <= 8'd0;
         rvalid_o     <= 1'b0;
         rdata_o      <= 32'd0;
      end else begin
         if (cycle_cnt_q != 32'hFFFF_FFFF) cycle_cnt_q <= cycle_cnt_q + 32'd1;
         rvalid_o <= req_i;
         rdata_o  <= rd ? read_mux : 32'd0;
         if (cfg_open && wr && word == 2'd0) exit_value_q <= wdata_i;
         // Software request has priority over a simultaneous watchdog expiry
         if (sw_exit)          exit_value_o <= exit_value_q;
         else if (wdog_expire) exit_value_o <= WDOG_EXIT_CODE;
         if (state_q == RUN)        drain_cnt_q <= 8'(DRAIN_CYCLES);
         else if (state_q == DRAIN) drain_cnt_q <= drain_cnt_q - 8'd1;
      end
   end

endmodule

// File: tb/tb_exit_ctrl.sv
// Scoreboard testbench for exit_ctrl: read/write responses are queued at issue and checked on rvalid.
// Watchdog scenarios run only when EXIT_CTRL_WDOG_EN is defined.
module tb_exit_ctrl;

   localparam logic [3:0] ADDR_VALUE = 4'h0;
   localparam logic [3:0] ADDR_CTRL  = 4'h4;
   localparam logic [3:0] ADDR_WDOG  = 4'h8;
   localparam logic [3:0] ADDR_CNT   = 4'hC;

   typedef struct {
      string       tag;
      logic [31:0] data;
   } exp_t;

   logic        clk_i   = 1'b0;
   logic        rst_i   = 1'b1;
   logic        req_i   = 1'b0;
   logic        we_i    = 1'b0;
   logic [3:0]  addr_i  = 4'h0;
   logic [31:0] wdata_i = 32'h0;
   logic        gnt_o, rvalid_o, exit_valid_o;
   logic [31:0] rdata_o, exit_value_o;

   int          numChecks = 0;
   int          numFails  = 0;
   exp_t        sbQueue[$];
   exp_t        sbEntry;
   logic [31:0] expCycle    = 32'h0;
   logic        grantedLast = 1'b0;

   exit_ctrl #(.DRAIN_CYCLES(16), .WDOG_EXIT_CODE(32'hDEAD_0001)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
      .exit_valid_o(exit_valid_o), .exit_value_o(exit_value_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Reference cycle counter and grant tracker, advanced from the bench's own stimulus
   always @(posedge clk_i) begin
      if (rst_i) expCycle <= 32'h0;
      else if (expCycle != 32'hFFFF_FFFF) expCycle <= expCycle + 32'h1;
      grantedLast <= req_i && !rst_i;
   end

   always @(negedge clk_i) begin
      if (grantedLast) begin
         checkOutput("rvalid_pulse", {31'b0, rvalid_o}, 32'h1);
         if (sbQueue.size() == 0) begin
            checkOutput("sb_unexpected", 32'h1, 32'h0);
         end else begin
            sbEntry = sbQueue.pop_front();
            checkOutput(sbEntry.tag, rdata_o, sbEntry.data);
         end
      end else begin
         checkOutput("rvalid_idle", {31'b0, rvalid_o}, 32'h0);
      end
   end

   task automatic applyStimulus(input logic write, input logic [3:0] addr, input logic [31:0] data,
                                input logic [31:0] expRead, input string tag);
      exp_t e;
      req_i   = 1'b1;
      we_i    = write;
      addr_i  = addr;
      wdata_i = data;
      e.tag   = tag;
      e.data  = write ? 32'h0 : expRead;
      sbQueue.push_back(e);
      #1 checkOutput({tag, "_gnt"}, {31'b0, gnt_o}, 32'h1);
      @(posedge clk_i);
      #1;
      req_i = 1'b0;
      we_i  = 1'b0;
   endtask

   task automatic writeReg(input logic [3:0] addr, input logic [31:0] data, input string tag);
      applyStimulus(1'b1, addr, data, 32'h0, tag);
   endtask

   task automatic readReg(input logic [3:0] addr, input logic [31:0] expected, input string tag);
      applyStimulus(1'b0, addr, 32'h0, expected, tag);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic doReset();
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   // Called just after the grant edge of an exit request
   task automatic checkExitTiming(input int drainCycles, input logic [31:0] expValue, input string tag);
      for (int k = 0; k <= drainCycles + 1; k++) begin
         @(negedge clk_i);
         checkOutput($sformatf("%s_valid%0d", tag, k), {31'b0, exit_valid_o}, {31'b0, k >= drainCycles});
      end
      checkOutput({tag, "_value"}, exit_value_o, expValue);
      @(posedge clk_i);
      #1;
   endtask

   task automatic waitExitValid(input int maxCycles, input string tag);
      int n = 0;
      while (!exit_valid_o && n < maxCycles) begin
         idleCycles(1);
         n++;
      end
      checkOutput(tag, {31'b0, exit_valid_o}, 32'h1);
   endtask

   initial begin
      #1_000_000;
      checkOutput("global_timeout", 32'h0, 32'h1);
      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      int guard;
      doReset();

      checkOutput("rst_exit_valid", {31'b0, exit_valid_o}, 32'h0);
      checkOutput("rst_exit_value", exit_value_o, 32'h0);
      checkOutput("rst_rdata", rdata_o, 32'h0);
      checkOutput("rst_gnt_idle", {31'b0, gnt_o}, 32'h0);
      readReg(ADDR_VALUE, 32'h0, "rst_value");
      readReg(ADDR_WDOG, 32'h0, "rst_wdog");
      readReg(ADDR_CTRL, 32'h0, "rst_ctrl");

      // Register map, aliasing and ignored writes
      writeReg(ADDR_VALUE, 32'hA5A5_1234, "wr_value");
      readReg(ADDR_VALUE, 32'hA5A5_1234, "rd_value");
      readReg(4'h3, 32'hA5A5_1234, "rd_value_alias");
      writeReg(4'h6, 32'hFFFF_FFFE, "wr_ctrl_nop");
      readReg(ADDR_CTRL, 32'h0, "rd_ctrl_wo");
      writeReg(ADDR_CNT, 32'h0, "wr_cnt_ignored");
      readReg(ADDR_CNT, expCycle, "rd_cnt");
      writeReg(ADDR_WDOG, 32'h0000_1234, "wr_wdog");
`ifdef EXIT_CTRL_WDOG_EN
      readReg(ADDR_WDOG, 32'h0000_1234, "rd_wdog");
`else
      readReg(ADDR_WDOG, 32'h0, "rd_wdog");
`endif
      writeReg(ADDR_WDOG, 32'h0, "wr_wdog_clear");
      checkOutput("run_no_exit", {31'b0, exit_valid_o}, 32'h0);

      // Cycle counter read exactly 100 cycles after reset
      doReset();
      guard = 0;
      while (expCycle != 32'd100 && guard < 200) begin
         idleCycles(1);
         guard++;
      end
      readReg(ADDR_CNT, 32'd100, "cnt_at_100");

      // Exit with value 0, then DONE holds and ignores writes
      doReset();
      writeReg(ADDR_VALUE, 32'h0, "wr_value0");
      writeReg(ADDR_CTRL, 32'h1, "exit_req0");
      checkExitTiming(16, 32'h0, "exit0");
      idleCycles(20);
      checkOutput("done_hold", {31'b0, exit_valid_o}, 32'h1);
      writeReg(ADDR_VALUE, 32'h77, "wr_value_done");
      readReg(ADDR_VALUE, 32'h0, "rd_value_done");
      checkOutput("done_value", exit_value_o, 32'h0);

      // Value frozen at request; writes during DRAIN ignored
      doReset();
      writeReg(ADDR_VALUE, 32'h6, "wr_value6");
      writeReg(ADDR_CTRL, 32'h2, "ctrl_bit1_nop");
      writeReg(ADDR_VALUE, 32'h5, "wr_value5");
      writeReg(ADDR_CTRL, 32'h1, "exit_req5");
      writeReg(ADDR_VALUE, 32'h9, "wr_value_drain");
      writeReg(ADDR_WDOG, 32'h21, "wr_wdog_drain");
      readReg(ADDR_VALUE, 32'h5, "rd_value_drain");
      writeReg(ADDR_CTRL, 32'h1, "exit_req_again");
      checkOutput("drain_value", exit_value_o, 32'h5);
      idleCycles(11);
      checkOutput("drain_valid15", {31'b0, exit_valid_o}, 32'h0);
      idleCycles(1);
      checkOutput("drain_valid16", {31'b0, exit_valid_o}, 32'h1);
      checkOutput("done_value5", exit_value_o, 32'h5);
      readReg(ADDR_WDOG, 32'h0, "rd_wdog_drain");

      // Reset during DRAIN aborts the exit
      doReset();
      writeReg(ADDR_VALUE, 32'h7, "wr_value7");
      writeReg(ADDR_CTRL, 32'h1, "exit_req7");
      idleCycles(5);
      doReset();
      for (int k = 0; k < 30; k++) begin
         idleCycles(1);
         checkOutput($sformatf("abort_valid%0d", k), {31'b0, exit_valid_o}, 32'h0);
      end
      checkOutput("abort_value", exit_value_o, 32'h0);
      readReg(ADDR_VALUE, 32'h0, "abort_rd_value");
      readReg(ADDR_CNT, expCycle, "abort_rd_cnt");
      writeReg(ADDR_VALUE, 32'hC0DE, "wr_value_rerun");
      writeReg(ADDR_CTRL, 32'h1, "exit_req_rerun");
      checkExitTiming(16, 32'hC0DE, "rerun");

`ifdef EXIT_CTRL_WDOG_EN
      // Watchdog expiry after 50 cycles
      doReset();
      writeReg(ADDR_WDOG, 32'd50, "wr_wdog50");
      for (int k = 0; k <= 66; k++) begin
         @(negedge clk_i);
         if (k == 49) checkOutput("wdog_value49", exit_value_o, 32'h0);
         if (k == 50) checkOutput("wdog_value50", exit_value_o, 32'hDEAD_0001);
         if (k == 65) checkOutput("wdog_valid65", {31'b0, exit_valid_o}, 32'h0);
         if (k == 66) checkOutput("wdog_valid66", {31'b0, exit_valid_o}, 32'h1);
      end
      @(posedge clk_i);
      #1;

      // Software request on the expiry cycle wins
      doReset();
      writeReg(ADDR_VALUE, 32'h3, "wr_value3");
      writeReg(ADDR_WDOG, 32'd4, "wr_wdog4");
      idleCycles(3);
      writeReg(ADDR_CTRL, 32'h1, "exit_req_race");
      checkOutput("race_value", exit_value_o, 32'h3);
      waitExitValid(20, "race_valid");
      checkOutput("race_value_done", exit_value_o, 32'h3);
`endif

      idleCycles(2);
      checkOutput("sb_drained", sbQueue.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/exit_ctrl.md
EXIT_CTRL -- requirements
Module: exit_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 16: cycles held in DRAIN before exit_valid_o rises; must be 1..255.
REQ-002 SHALL have parameter WDOG_EXIT_CODE, default 32'hDEAD_0001: exit value reported on watchdog expiry.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_i  input  1  OBI request.
REQ-006 SHALL have port we_i  input  1  write enable, 1 = write.
REQ-007 SHALL have port addr_i  input  4  byte offset; bits [1:0] ignored.
REQ-008 SHALL have port wdata_i  input  32  write data; byte enables not supported, writes are full-word.
REQ-009 SHALL have port gnt_o  output  1  grant.
REQ-010 SHALL have port rvalid_o  output  1  response valid.
REQ-011 SHALL have port rdata_o  output  32  read data.
REQ-012 SHALL have port exit_valid_o  output  1  simulation exit request to the harness.
REQ-013 SHALL have port exit_value_o  output  32  exit code; 0 = success.

Function
REQ-014 SHALL drive gnt_o = req_i combinationally; every request is accepted in the cycle it is presented.
REQ-015 SHALL assert rvalid_o for exactly one cycle, in the cycle after each grant, for reads and writes; for writes rdata_o = 0.
REQ-016 Register map: 0x0 EXIT_VALUE (RW); 0x4 EXIT_CTRL (WO, bit0 = exit request, reads 0); 0x8 WDOG_LIMIT (RW); 0xC CYCLE_CNT (RO).
REQ-017 SHALL ignore writes to CYCLE_CNT; reads of CYCLE_CNT SHALL return the count sampled in the grant cycle.
REQ-018 SHALL implement FSM RUN -> DRAIN -> DONE; reset state RUN.
REQ-019 In RUN, a write to EXIT_CTRL with wdata_i[0] = 1 SHALL move to DRAIN and freeze exit_value_o at the current EXIT_VALUE.
REQ-020 In DRAIN, a down-counter loaded with DRAIN_CYCLES SHALL decrement each cycle and move to DONE when it reaches 1.
REQ-021 In DONE, exit_valid_o SHALL be 1 and stay 1 until reset; exit_valid_o SHALL be 0 in RUN and DRAIN.
REQ-022 In DRAIN and DONE, writes to EXIT_VALUE, EXIT_CTRL and WDOG_LIMIT SHALL be granted and acknowledged but have no effect.
REQ-023 CYCLE_CNT SHALL increment by 1 every cycle out of reset, saturate at 32'hFFFF_FFFF, and keep counting in DRAIN and DONE.
REQ-024 A write to EXIT_VALUE in the same cycle as an EXIT_CTRL request cannot occur because there is one port; the value used is the one registered before the request cycle.
REQ-025 An unmapped offset cannot occur with a 4-bit address; offsets 0x1-0x3 etc. alias by word.

Reset
REQ-026 On rst_i = 1 at a clock edge: state = RUN, EXIT_VALUE = 0, WDOG_LIMIT = 0, CYCLE_CNT = 0, watchdog counter = 0, rvalid_o = 0, rdata_o = 0, exit_valid_o = 0, exit_value_o = 0.
REQ-027 Reset asserted in DRAIN or DONE SHALL abort the exit and return to RUN on the next edge.

Configuration
REQ-028 Macro EXIT_CTRL_WDOG_EN: when defined, a watchdog counter increments each cycle in RUN while WDOG_LIMIT != 0, and any write to WDOG_LIMIT clears it. When it reaches WDOG_LIMIT, the block enters DRAIN with exit_value_o = WDOG_EXIT_CODE.
REQ-029 With the macro defined, if an EXIT_CTRL request and watchdog expiry occur in the same cycle, the software request wins and its EXIT_VALUE is reported.
REQ-030 Without the macro, no watchdog logic is present, WDOG_LIMIT reads 0, and writes to WDOG_LIMIT are ignored.

Verification
REQ-031 Write EXIT_VALUE=0, then EXIT_CTRL=1 -> exit_valid_o rises exactly 16 cycles after the request cycle, exit_value_o = 0.
REQ-032 Write EXIT_VALUE=5, EXIT_CTRL=1, then EXIT_VALUE=9 during DRAIN -> exit_value_o = 5 and reads of EXIT_VALUE return 5.
REQ-033 Read CYCLE_CNT at cycle 100 after reset -> rdata_o = 100 one cycle later, with rvalid_o high for exactly 1 cycle.
REQ-034 With EXIT_CTRL_WDOG_EN defined, write WDOG_LIMIT=50 and issue no further writes -> DRAIN is entered after 50 cycles, then exit_value_o = 32'hDEAD_0001.
REQ-035 With EXIT_CTRL_WDOG_EN defined, EXIT_CTRL=1 issued in the same cycle as watchdog expiry with EXIT_VALUE=3 -> exit_value_o = 3.
REQ-036 Pulse rst_i for 1 cycle during DRAIN -> exit_valid_o never rises, all registers return to 0, and the block is back in RUN.
